// File: rtl/demo_bus_pkg.sv
// Shared definitions for the demo system bus: request mode codes, responder state encoding, default window base.
// Latency: none (type and constant definitions only).
// Backpressure: not applicable.
package demo_bus_pkg;

  // Request direction carried on s_mode
  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_e;

  // Default base of the responder's address window
  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h1000;

endpackage

// File: rtl/demo_reg_mem.sv
// Small register file backing the responder: synchronous write, asynchronous read, synchronous clear.
// Latency: write lands at the clock edge; read data follows raddr combinationally.
// Backpressure: none; a write is taken on every cycle that we is high.
module demo_reg_mem #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // Next contents: hold everything, overwrite the addressed entry on a write
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage registers; reset clears every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/demo_slave_responder.sv
// Bus slave responder: accepts one read/write request, waits WAIT_CYCLES, answers with a one-cycle s_rvalid pulse.
// Latency: request accepted at edge N gives s_rvalid in cycle N+1+WAIT_CYCLES; next accept possible one cycle later.
// Backpressure: s_ready is high only in IDLE; s_valid is ignored while a request is in flight (no queueing).
module demo_slave_responder
  import demo_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    MEM_ADDR_WIDTH = 5,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
  parameter int                    WAIT_CYCLES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  input  logic                      s_mode,
  input  logic [ADDR_WIDTH-1:0]     s_addr,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  output logic                      s_ready,
  output logic                      s_rvalid,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic                      s_err,
  output logic [7:0]                wr_count,
  output logic [MEM_ADDR_WIDTH-1:0] last_addr
);

  localparam int              CNT_W     = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  resp_state_e state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic [7:0]                wr_count_q, wr_count_d;
  logic [MEM_ADDR_WIDTH-1:0] last_addr_q, last_addr_d;

  logic                      enter_resp;
  logic                      req_mode;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic                      in_window;
  logic [MEM_ADDR_WIDTH-1:0] offset;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  // Request seen at RESP entry: the live bus in IDLE (zero-wait case), otherwise the captured copy
  always_comb begin
    req_mode  = mode_q;
    req_addr  = addr_q;
    req_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      req_mode  = s_mode;
      req_addr  = s_addr;
      req_wdata = s_wdata;
    end
    in_window = (req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH] == BASE_ADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH]);
    offset    = req_addr[MEM_ADDR_WIDTH-1:0];
  end

  // FSM next state, request capture and wait countdown
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          mode_d  = s_mode;
          addr_d  = s_addr;
          wdata_d = s_wdata;
          cnt_d   = WAIT_LOAD;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Response data, error flag, write counter and last offset, all loaded on the edge entering RESP
  always_comb begin
    rdata_d     = rdata_q;
    err_d       = err_q;
    wr_count_d  = wr_count_q;
    last_addr_d = last_addr_q;
    mem_we      = 1'b0;
    if (enter_resp) begin
      if (in_window) begin
        err_d       = 1'b0;
        last_addr_d = offset;
        if (req_mode == MODE_WRITE) begin
          mem_we     = 1'b1;
          rdata_d    = req_wdata;
          wr_count_d = wr_count_q + 8'd1;
        end else begin
          rdata_d = mem_rdata;
        end
      end else begin
        err_d   = 1'b1;
        rdata_d = '0;
      end
    end
  end

  // State and datapath registers; reset drops any in-flight request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      wr_count_q  <= '0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      wr_count_q  <= wr_count_d;
      last_addr_q <= last_addr_d;
    end
  end

  demo_reg_mem #(
    .AW (MEM_ADDR_WIDTH),
    .DW (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (offset),
    .wdata (req_wdata),
    .raddr (offset),
    .rdata (mem_rdata)
  );

  assign s_ready   = (state_q == ST_IDLE);
  assign s_rvalid  = (state_q == ST_RESP);
  assign s_rdata   = rdata_q;
  assign s_err     = err_q;
  assign wr_count  = wr_count_q;
  assign last_addr = last_addr_q;

endmodule

// File: tb/tb_demo_slave_responder.sv
// Bench for demo_slave_responder: a 2-wait-state and a 0-wait-state instance checked against a transaction-level model.
// Latency: not applicable.
// Backpressure: requests are only driven while the selected instance shows s_ready.
module tb_demo_slave_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wd = '0;
  int          sel = 0;   // 0: WAIT_CYCLES=2 instance, 1: WAIT_CYCLES=0 instance

  logic       rdy2, rv2, er2, rdy0, rv0, er0;
  logic [7:0] rd2, wc2, rd0, wc0;
  logic [4:0] la2, la0;

  wire v2 = valid && (sel == 0);
  wire v0 = valid && (sel == 1);

  wire       rdy_m = (sel == 1) ? rdy0 : rdy2;
  wire       rv_m  = (sel == 1) ? rv0  : rv2;
  wire       er_m  = (sel == 1) ? er0  : er2;
  wire [7:0] rd_m  = (sel == 1) ? rd0  : rd2;
  wire [7:0] wc_m  = (sel == 1) ? wc0  : wc2;
  wire [4:0] la_m  = (sel == 1) ? la0  : la2;

  demo_slave_responder #(.WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .s_valid(v2), .s_mode(mode), .s_addr(addr), .s_wdata(wd),
    .s_ready(rdy2), .s_rvalid(rv2), .s_rdata(rd2), .s_err(er2), .wr_count(wc2), .last_addr(la2)
  );

  demo_slave_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .s_valid(v0), .s_mode(mode), .s_addr(addr), .s_wdata(wd),
    .s_ready(rdy0), .s_rvalid(rv0), .s_rdata(rd0), .s_err(er0), .wr_count(wc0), .last_addr(la0)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mdl_mem [2][32];
  int         mdl_wc [2];
  int         mdl_la [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input logic [15:0] a);
    return (a >= 16'h1000) && (a < 16'h1020);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) mdl_mem[d][i] = 8'h00;
      mdl_wc[d] = 0;
      mdl_la[d] = 0;
    end
  endtask

  // Apply one transaction to the model of the selected instance; return the expected response
  task automatic model_apply(input logic m, input logic [15:0] a, input logic [7:0] d,
                             output logic [7:0] exp_rd, output logic exp_err);
    int off;
    off = a - 16'h1000;
    if (in_win(a)) begin
      exp_err = 1'b0;
      if (m) begin
        mdl_mem[sel][off] = d;
        exp_rd = d;
        mdl_wc[sel] = (mdl_wc[sel] + 1) % 256;
      end else begin
        exp_rd = mdl_mem[sel][off];
      end
      mdl_la[sel] = off;
    end else begin
      exp_err = 1'b1;
      exp_rd  = 8'h00;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready2"}, rdy2, 1);  chk({tag, "_ready0"}, rdy0, 1);
    chk({tag, "_rvalid2"}, rv2, 0);  chk({tag, "_rvalid0"}, rv0, 0);
    chk({tag, "_rdata2"}, rd2, 0);   chk({tag, "_rdata0"}, rd0, 0);
    chk({tag, "_err2"}, er2, 0);     chk({tag, "_err0"}, er0, 0);
    chk({tag, "_wrcnt2"}, wc2, 0);   chk({tag, "_wrcnt0"}, wc0, 0);
    chk({tag, "_last2"}, la2, 0);    chk({tag, "_last0"}, la0, 0);
  endtask

  // One full transaction on the selected instance, starting and ending at a falling edge in IDLE
  task automatic do_req(input logic m, input logic [15:0] a, input logic [7:0] d);
    int         cyc;
    int         lat;
    logic [7:0] exp_rd;
    logic       exp_err;
    lat = (sel == 1) ? 1 : 3;
    chk("ready_before_req", rdy_m, 1);
    mode = m; addr = a; wd = d; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    cyc = 1;
    while (!rv_m && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    model_apply(m, a, d, exp_rd, exp_err);
    chk("latency", cyc, lat);
    chk("rdata", rd_m, exp_rd);
    chk("err", er_m, exp_err);
    chk("wr_count", wc_m, mdl_wc[sel]);
    chk("last_addr", la_m, mdl_la[sel]);
    @(negedge clk);
    chk("rvalid_one_cycle", rv_m, 0);
    chk("ready_after_resp", rdy_m, 1);
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 3) != 0) return 16'h1000 + 16'($urandom_range(0, 31));
    return 16'($urandom());
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_rd;
    logic       exp_err;
    logic [7:0] exp_q_rd [$];
    logic       exp_q_err [$];
    logic [7:0] x_rd;
    logic       x_err;
    int         prev;
    int         cycle;
    int         accepted;
    int         responses;
    int         rcount;

    // Reset held three cycles
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed sequence on the 2-wait-state instance
    sel = 0;
    do_req(1'b1, 16'h1003, 8'hA5);
    do_req(1'b0, 16'h1003, 8'h00);
    chk("readback_1003", rd2, 8'hA5);
    do_req(1'b0, 16'h101F, 8'h00);
    chk("top_offset_last", la2, 5'd31);
    do_req(1'b0, 16'h1000, 8'h00);
    do_req(1'b1, 16'h2003, 8'h11);
    chk("oow_err", er2, 1);
    chk("oow_wrcnt", wc2, 1);
    do_req(1'b0, 16'h1003, 8'h00);
    chk("reread_1003", rd2, 8'hA5);

    // Randomized traffic on both instances
    for (int i = 0; i < 40; i++) begin
      sel = (i % 2);
      do_req(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom()));
    end

    // s_valid held high: junk during WAIT/RESP must be ignored, one response every 4 cycles
    sel = 0;
    prev = -1; cycle = 0; accepted = 0; responses = 0;
    while (cycle < 60) begin
      if (rv_m) begin
        x_rd  = exp_q_rd.pop_front();
        x_err = exp_q_err.pop_front();
        chk("hold_rdata", rd_m, x_rd);
        chk("hold_err", er_m, x_err);
        chk("hold_wrcnt", wc_m, mdl_wc[0]);
        if (prev >= 0) chk("hold_period", cycle - prev, 4);
        prev = cycle;
        responses++;
        if (responses == 4) valid = 1'b0;
        else begin
          addr = 16'($urandom()); mode = 1'($urandom()); wd = 8'($urandom());
        end
      end else if (rdy_m) begin
        if (accepted == 4) break;
        mode = (accepted % 2 == 0) ? 1'b1 : 1'b0;
        addr = 16'h1008 + 16'(accepted / 2);
        wd   = 8'($urandom());
        valid = 1'b1;
        model_apply(mode, addr, wd, exp_rd, exp_err);
        exp_q_rd.push_back(exp_rd);
        exp_q_err.push_back(exp_err);
        accepted++;
      end else begin
        addr = 16'($urandom()); mode = 1'($urandom()); wd = 8'($urandom());
      end
      @(negedge clk);
      cycle++;
    end
    valid = 1'b0;
    chk("hold_responses", responses, 4);

    // Reset during WAIT of a write to 0x1004: no response, write discarded
    sel = 0;
    mode = 1'b1; addr = 16'h1004; wd = 8'h77; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b1;
    rcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (rv2) rcount++;
    end
    chk("reset_in_wait_no_rvalid", rcount, 0);
    chk_reset_state("midreset");
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    do_req(1'b0, 16'h1004, 8'h00);
    chk("reset_discarded_write", rd2, 8'h00);

    // 256 in-window writes on the zero-wait instance: counter wraps back to 0
    sel = 1;
    for (int i = 0; i < 256; i++) begin
      do_req(1'b1, 16'h1000 + 16'(i % 32), 8'($urandom()));
    end
    chk("wr_count_wrap", wc0, 0);
    for (int i = 0; i < 10; i++) begin
      do_req(1'b0, 16'h1000 + 16'($urandom_range(0, 31)), 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
